// File: rtl/mips_fetch_if.sv
// mips_fetch_if: fetch-unit bus bundling enable, instruction-memory port, decode handshake and redirect.
// The master modport is the fetch unit; the slave modport is the memory/decode/branch side.
interface mips_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  en;
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic [ADDR_WIDTH-1:0] inst_pc4;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  busy;
    logic                  misalign;
    modport master (
        input  en, imem_ack, imem_rdata, inst_ready, redirect, redirect_pc,
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4, busy, misalign
    );
    modport slave (
        output en, imem_ack, imem_rdata, inst_ready, redirect, redirect_pc,
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4, busy, misalign
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: fetch PC, variable-latency req/ack memory port and BUF_DEPTH-entry instruction buffer.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of silently aligning them.
module mips_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    STEP         = 4,
    parameter int                    BUF_DEPTH    = 2
) (
    input logic        clk,
    input logic        rst,
    mips_fetch_if.master bus
);
    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0]         DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [PW-1:0]         LAST_C  = PW'(BUF_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] LOW_C   = ADDR_WIDTH'(STEP - 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, r_addr, w_redir_pc;
    logic [DATA_WIDTH-1:0] r_buf_data [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] r_buf_pc [BUF_DEPTH];
    logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_misalign, w_bad, w_issue, w_xfer, w_push, w_pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_bad      = (bus.redirect_pc & LOW_C) != '0;
    assign w_redir_pc = bus.redirect_pc;
`else
    assign w_bad      = 1'b0;
    assign w_redir_pc = bus.redirect_pc & ~LOW_C;
`endif

    // Issue only into a free slot; an outstanding request already owns one.
    assign w_issue        = r_state == IDLE && bus.en && !bus.redirect && r_count < DEPTH_C && !r_misalign;
    assign bus.imem_req   = !rst && (r_state != IDLE || w_issue);
    assign bus.imem_addr  = r_state == IDLE ? r_fetch_pc : r_addr;
    assign w_xfer         = bus.imem_req && bus.imem_ack;
    assign w_push         = w_xfer && r_state != DROP && !bus.redirect;
    assign w_pop          = bus.inst_valid && bus.inst_ready && !bus.redirect;
    assign bus.inst_valid = r_count != '0;
    assign bus.inst_data  = r_buf_data[r_rd_ptr];
    assign bus.inst_pc    = r_buf_pc[r_rd_ptr];
    assign bus.inst_pc4   = bus.inst_pc + STEP_C;
    assign bus.busy       = bus.imem_req || r_count != '0;
    assign bus.misalign   = r_misalign;

    always_comb begin
        w_next = (w_xfer || !bus.imem_req) ? IDLE : (bus.redirect || r_state == DROP) ? DROP : REQ;
    end

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_VECTOR;
            r_addr     <= RESET_VECTOR;
            r_misalign <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else begin
            if (r_state == IDLE)
                r_addr <= r_fetch_pc;
            if (bus.redirect) begin
                r_fetch_pc <= w_redir_pc;
                r_misalign <= w_bad;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_buf_data[r_wr_ptr] <= bus.imem_rdata;
                    r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
                    r_fetch_pc           <= r_fetch_pc + STEP_C;
                    r_wr_ptr             <= r_wr_ptr == LAST_C ? '0 : r_wr_ptr + PW'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr == LAST_C ? '0 : r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch front end for the MIPS CPU. It replaces the free-running PC counter and the hard-wired instruction ROM read with three parts: a fetch PC register, a req/ack instruction-memory port that tolerates variable latency, and a BUF_DEPTH-entry instruction buffer. The buffer feeds decode over a valid/ready handshake. Branch, jump and jump-register targets resolved downstream return through a single redirect port, which flushes the buffer and discards any in-flight fetch.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC and memory address width
- RESET_VECTOR, 0, first fetch address after reset
- STEP, 4, sequential PC increment; must be a power of two
- BUF_DEPTH, 2, instruction buffer entries, ≥1

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  fetch enable; 0 blocks new requests, drain continues
- imem_req  out  1  instruction memory request
- imem_addr  out  ADDR_WIDTH  request address; stable while imem_req=1 and not acked
- imem_ack  in  1  transfer completes on an edge where imem_req & imem_ack
- imem_rdata  in  DATA_WIDTH  instruction word, valid with imem_ack
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  decode accepts head when inst_valid & inst_ready
- inst_data  out  DATA_WIDTH  head instruction
- inst_pc  out  ADDR_WIDTH  head PC
- inst_pc4  out  ADDR_WIDTH  inst_pc + STEP, mod 2^ADDR_WIDTH
- redirect  in  1  take redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address
- busy  out  1  request outstanding or buffer non-empty
- misalign  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State machine:
  - IDLE: no request outstanding.
  - REQ: imem_req=1, waiting for ack.
  - DROP: imem_req=1, waiting for ack; returned data is discarded.
- Issue rule: from IDLE or from an acked REQ, drive imem_req=1 with imem_addr=fetch_pc when all of the following hold:
  - en=1
  - no redirect this cycle
  - count + pending < BUF_DEPTH, where pending is the slot already reserved by the request being acked
  - misalign=0
- Request hold: imem_req stays high and imem_addr stays fixed until ack. en falling does not withdraw a raised request.
- On ack in REQ: push {fetch_pc, imem_rdata} into the buffer, then fetch_pc += STEP. The PC wraps modulo 2^ADDR_WIDTH.
- Back-to-back: on an ack edge, if the issue rule still holds, the next cycle presents a new address with imem_req still high.
- Buffer ordering:
  - FIFO order.
  - Push and pop in the same cycle are both honoured.
  - Occupancy never exceeds BUF_DEPTH, because space is reserved at issue.
- Redirect (highest priority after rst):
  - Flush the buffer, so inst_valid=0 the next cycle.
  - Set fetch_pc := redirect_pc.
  - A pop in the same cycle is ignored.
  - If a request is outstanding and not acked that cycle, go to DROP. In DROP the ack is consumed without a push, then the unit issues to redirect_pc.
  - If ack coincides with redirect, discard the data.
  - Redirect while already in DROP updates fetch_pc to the newest redirect_pc.
- Reset:
  - rst wins over every other input.
  - Mid-transaction, the unit drops the request immediately; the memory must tolerate a withdrawn request on reset.
  - Reset values: imem_req=0, imem_addr=RESET_VECTOR, inst_valid=0, inst_data=0, inst_pc=0, inst_pc4=STEP, busy=0, misalign=0, state IDLE, buffer empty.

## Timing
- First request: the cycle after rst deasserts, if en=1.
- Ack to decode: ack at edge N gives inst_valid=1 in cycle N+1. All buffer outputs are registered; there is no combinational rdata→inst_data path.
- Redirect latency:
  - Redirect at edge N with nothing outstanding: imem_req=1, imem_addr=redirect_pc in cycle N+1.
  - With a request outstanding: the first cycle after the dropped ack.
- Throughput: with zero-wait memory (ack in the request's first cycle), inst_ready=1 and BUF_DEPTH≥2, one instruction per cycle.
- Full buffer with inst_ready=0: the memory port goes idle. It resumes the cycle after a pop frees a slot.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect_pc with nonzero low log2(STEP) bits sets misalign=1 the next cycle.
  - The buffer is flushed and no further requests issue.
  - misalign clears only on rst, or on an aligned redirect.
- FETCH_MISALIGN_TRAP_EN undefined:
  - The low log2(STEP) bits of redirect_pc are forced to zero.
  - misalign is tied to 0.

## Test plan
- Reset then stream: rst 2 cycles, en=1, zero-wait ack, inst_ready=1. Expect requests to 0x0, 0x4, 0x8, … on consecutive cycles and inst_pc following one cycle behind, with inst_pc4=inst_pc+4.
- Backpressure: inst_ready=0 for 6 cycles. Expect exactly 2 pushes with imem_req low thereafter; on release, ordered output 0x0 then 0x4 and requests resume the next cycle.
- Redirect mid-flight: ack delayed 3 cycles on address 0x8; assert redirect to 0x40 in the wait. Expect imem_addr to hold 0x8 until ack, that data never to appear on inst_data, and the next request to be 0x40.
- Redirect coincident with ack and pop: the cycle after, inst_valid=0, and the next instruction delivered has inst_pc=redirect_pc.
- Wrap: redirect to 0xFFFFFFFC. Expect the following fetch at 0x00000000 and inst_pc4=0x0 for the 0xFFFFFFFC entry.
- Misalign: redirect_pc=0x42.
  - With FETCH_MISALIGN_TRAP_EN: misalign=1 and no request until a redirect to 0x44.
  - Without it: fetch at 0x40.
